// File: rtl/addsub_issue_stage.sv
// Issue/capture stage around a combinational adder/subtractor: registers one
// operation, drives it to the arithmetic unit, captures ANSWER plus local flags.
module addsub_issue_stage #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_s,
    input  logic [WIDTH-1:0] au_answer,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_mismatch
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             s_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;
    logic             mismatch_r;

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   sum_s;
    logic             overflow_s;

    // Signed overflow: operands of matching effective sign producing a result of the other sign.
    function automatic logic calc_overflow(input logic sub, input logic a_msb,
                                           input logic b_msb, input logic r_msb);
        logic same_sign;
        same_sign = sub ? (a_msb != b_msb) : (a_msb == b_msb);
        return same_sign & (r_msb != a_msb);
    endfunction

    // Independent reference sum; subtraction is a + ~b + 1 so the carry reads as "no borrow".
    always_comb begin
        b_eff_s    = {WIDTH{1'b0}};
        sum_s      = {(WIDTH+1){1'b0}};
        overflow_s = 1'b0;
        if (s_r) begin
            b_eff_s = ~b_r;
        end else begin
            b_eff_s = b_r;
        end
        sum_s      = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, s_r};
        overflow_s = calc_overflow(s_r, a_r[WIDTH-1], b_r[WIDTH-1], sum_s[WIDTH-1]);
    end

    // Control FSM plus operand and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            s_r         <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            mismatch_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        s_r        <= in_sub;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    result_r    <= au_answer;
                    carry_r     <= sum_s[WIDTH];
                    overflow_r  <= overflow_s;
                    zero_r      <= (au_answer == {WIDTH{1'b0}});
                    mismatch_r  <= (au_answer != sum_s[WIDTH-1:0]);
                    out_valid_r <= 1'b1;
                    state_r     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign au_a         = a_r;
    assign au_b         = b_r;
    assign au_s         = s_r;
    assign out_result   = result_r;
    assign out_carry    = carry_r;
    assign out_overflow = overflow_r;
    assign out_zero     = zero_r;
    assign out_mismatch = mismatch_r;

endmodule
